// File: rtl/conv_pkg.sv
// Shared types and helpers for the 3x3 streaming convolution.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN
  } conv_state_t;

  // Sharpen kernel, row-major, oldest row first.
  localparam int DEF_KERNEL [0:8] = '{0, -1, 0, -1, 5, -1, 0, -1, 0};

  function automatic int unsigned acc_width(input int unsigned pix_w, input int unsigned coef_w);
    return pix_w + coef_w + 5;
  endfunction

  function automatic logic signed [63:0] clamp_pix(input logic signed [63:0] v,
                                                   input int unsigned     pix_w);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< pix_w) - 64'sd1;
    if (v < 64'sd0) return '0;
    if (v > hi)     return hi;
    return v;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Two-row ring of line memories; the row being written replaces the oldest one.
module conv_line_buffer #(
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned MAX_LINE = 2820
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [11:0]      i_addr,
  input  logic [PIX_W-1:0] i_data,
  input  logic             i_flip,
  output logic [PIX_W-1:0] o_tap_old,
  output logic [PIX_W-1:0] o_tap_mid
);

  logic [PIX_W-1:0] r_mem_a [MAX_LINE];
  logic [PIX_W-1:0] r_mem_b [MAX_LINE];
  logic             r_wsel;

  always_ff @(posedge clk) begin
    if (i_we && !r_wsel) r_mem_a[i_addr] <= i_data;
    if (i_we &&  r_wsel) r_mem_b[i_addr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_wsel <= 1'b0;
    else if (i_flip) r_wsel <= !r_wsel;
  end

  // Read-before-write: the bank being written still holds row current-2.
  assign o_tap_old = r_wsel ? r_mem_b[i_addr] : r_mem_a[i_addr];
  assign o_tap_mid = r_wsel ? r_mem_a[i_addr] : r_mem_b[i_addr];

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 signed-kernel convolution over interleaved multi-channel rows.
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned COEF_W   = 8,
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned MAX_LINE = 2820,
  parameter int unsigned SHIFT    = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [11:0]       cfg_line_len,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [COEF_W-1:0] cfg_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PIX_W-1:0]  s_data,
  input  logic              s_sof,
  input  logic              s_eol,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [PIX_W-1:0]  m_data,
  output logic              m_eol,
  output logic              busy,
  output logic              err_len
);

  localparam int unsigned ACC_W  = acc_width(PIX_W, COEF_W);
  localparam int unsigned PROD_W = PIX_W + COEF_W + 1;
  localparam int unsigned SR_D   = 2 * CHANNELS;
  localparam logic [11:0] WIN_C  = 12'(SR_D);

  conv_state_t              r_state;
  logic [11:0]              r_col, r_len;
  logic [1:0]               r_row;
  logic                     r_err, r_rdy_en;
  logic signed [COEF_W-1:0] r_coef   [9];
  logic [PIX_W-1:0]         r_sr_old [SR_D];
  logic [PIX_W-1:0]         r_sr_mid [SR_D];
  logic [PIX_W-1:0]         r_sr_cur [SR_D];
  logic signed [PROD_W-1:0] r_prod   [9];
  logic                     r_s1_valid, r_s1_eol;
  logic                     r_m_valid, r_m_eol;
  logic [PIX_W-1:0]         r_m_data;

  logic                     w_adv, w_accept, w_active, w_produce;
  logic [11:0]              w_col_cur, w_len, w_cnt;
  logic                     w_full, w_row_end, w_len_err;
  logic [PIX_W-1:0]         w_tap_old, w_tap_mid;
  logic [PIX_W-1:0]         w_taps   [9];
  logic signed [PROD_W-1:0] w_prod   [9];
  logic signed [ACC_W-1:0]  w_acc;

  assign w_adv     = !r_m_valid || m_ready;
  assign s_ready   = r_rdy_en && ((r_state == ST_IDLE) || w_adv);
  assign w_accept  = s_valid && s_ready;
  assign w_active  = w_accept && ((r_state != ST_IDLE) || s_sof);
  assign w_col_cur = s_sof ? '0 : r_col;
  assign w_len     = s_sof ? cfg_line_len : r_len;
  assign w_cnt     = w_col_cur + 12'd1;
  assign w_full    = (w_cnt == w_len);
  // s_sof outranks s_eol, so a start sample never closes or flags a row.
  assign w_row_end = !s_sof && (s_eol || w_full);
  assign w_len_err = !s_sof && (s_eol != w_full);
  assign w_produce = w_active && !s_sof && (r_state == ST_RUN) && (w_col_cur >= WIN_C);

  conv_line_buffer #(
    .PIX_W    (PIX_W),
    .MAX_LINE (MAX_LINE)
  ) u_line_buffer (
    .clk       (clock),
    .rst_n     (reset),
    .i_we      (w_active),
    .i_addr    (w_col_cur),
    .i_data    (s_data),
    .i_flip    (w_active && w_row_end),
    .o_tap_old (w_tap_old),
    .o_tap_mid (w_tap_mid)
  );

  always_comb begin
    w_taps[0] = r_sr_old[SR_D-1];
    w_taps[1] = r_sr_old[CHANNELS-1];
    w_taps[2] = w_tap_old;
    w_taps[3] = r_sr_mid[SR_D-1];
    w_taps[4] = r_sr_mid[CHANNELS-1];
    w_taps[5] = w_tap_mid;
    w_taps[6] = r_sr_cur[SR_D-1];
    w_taps[7] = r_sr_cur[CHANNELS-1];
    w_taps[8] = s_data;
    for (int unsigned k = 0; k < 9; k++)
      w_prod[k] = PROD_W'($signed({1'b0, w_taps[k]})) * PROD_W'(r_coef[k]);
  end

  always_comb begin
    w_acc = '0;
    for (int unsigned k = 0; k < 9; k++)
      w_acc = w_acc + ACC_W'(r_prod[k]);
  end

  always_ff @(posedge clock) begin
    if (w_active) begin
      r_sr_old[0] <= w_tap_old;
      r_sr_mid[0] <= w_tap_mid;
      r_sr_cur[0] <= s_data;
      for (int unsigned i = 1; i < SR_D; i++) begin
        r_sr_old[i] <= r_sr_old[i-1];
        r_sr_mid[i] <= r_sr_mid[i-1];
        r_sr_cur[i] <= r_sr_cur[i-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_col    <= '0;
      r_len    <= '0;
      r_row    <= '0;
      r_err    <= 1'b0;
      r_rdy_en <= 1'b0;
      for (int unsigned k = 0; k < 9; k++)
        r_coef[k] <= COEF_W'(DEF_KERNEL[k]);
    end else begin
      r_rdy_en <= 1'b1;
      if ((r_state == ST_IDLE) && cfg_we && (cfg_addr <= 4'd8))
        r_coef[cfg_addr] <= cfg_data;
      if (w_active) begin
        if (s_sof) begin
          r_state <= ST_FILL;
          r_len   <= cfg_line_len;
          r_col   <= 12'd1;
          r_row   <= '0;
          r_err   <= 1'b0;
        end else if (w_row_end) begin
          r_col <= '0;
          if (r_row != 2'd2) r_row <= r_row + 2'd1;
          if ((r_state == ST_FILL) && (r_row == 2'd1)) r_state <= ST_RUN;
          if (w_len_err) r_err <= 1'b1;
        end else begin
          r_col <= w_cnt;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < 9; k++) r_prod[k] <= '0;
      r_s1_valid <= 1'b0;
      r_s1_eol   <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_eol    <= 1'b0;
      r_m_data   <= '0;
    end else if (w_adv) begin
      for (int unsigned k = 0; k < 9; k++) r_prod[k] <= w_prod[k];
      r_s1_valid <= w_produce;
      r_s1_eol   <= w_produce && w_row_end;
      r_m_valid  <= r_s1_valid;
      r_m_eol    <= r_s1_valid && r_s1_eol;
      if (r_s1_valid)
        r_m_data <= PIX_W'(clamp_pix(64'(w_acc >>> SHIFT), PIX_W));
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_eol   = r_m_eol;
  assign busy    = (r_state != ST_IDLE);
  assign err_len = r_err;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Randomised bench for conv3x3_stream against a frame-level convolution model.
module tb_conv3x3_stream;

  localparam int CH       = 3;
  localparam int TB_SHIFT = 0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] cfg_line_len = '0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [7:0]  cfg_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic        s_sof = 1'b0;
  logic        s_eol = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [7:0]  m_data;
  logic        m_eol;
  logic        busy;
  logic        err_len;

  always #5 clock = ~clock;

  conv3x3_stream #(
    .PIX_W    (8),
    .COEF_W   (8),
    .CHANNELS (CH),
    .MAX_LINE (2820),
    .SHIFT    (TB_SHIFT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_line_len (cfg_line_len),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_sof        (s_sof),
    .s_eol        (s_eol),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_eol        (m_eol),
    .busy         (busy),
    .err_len      (err_len)
  );

  typedef struct { int data; bit sof; bit eol; } smp_t;
  typedef struct { int data; bit eol; } out_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   img  [0:7][0:31];
  int   rlen [0:7];
  int   kern [0:8];
  int   first_prod_idx;
  smp_t stim [$];
  out_t expq [$];

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_default_kernel();
    kern = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
  endtask

  // mode: 0 random, 1 ramp, 2 flat val, 3 same-channel checkerboard of val/0
  task automatic build_frame(input int rows, input int len, input int mode, input int val,
                             input int short_row, input int short_len);
    int acc;
    stim.delete();
    expq.delete();
    cfg_line_len = 12'(len);
    for (int r = 0; r < rows; r++) begin
      rlen[r] = len;
      for (int c = 0; c < len; c++) begin
        case (mode)
          0:       img[r][c] = int'($urandom_range(0, 255));
          1:       img[r][c] = (r * len + c) % 256;
          2:       img[r][c] = val;
          default: img[r][c] = (((r + c / CH) % 2) == 1) ? val : 0;
        endcase
      end
    end
    if (short_row >= 2) begin
      rlen[short_row] = short_len;
      // unsent columns of a short row keep what the line memory held two rows earlier
      for (int c = short_len; c < len; c++) img[short_row][c] = img[short_row-2][c];
    end
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < rlen[r]; c++)
        stim.push_back('{img[r][c], (r == 0 && c == 0), (c == rlen[r] - 1)});
    first_prod_idx = rlen[0] + rlen[1] + 2 * CH;
    for (int r = 2; r < rows; r++)
      for (int c = 2 * CH; c < rlen[r]; c++) begin
        acc = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            acc += kern[i*3+j] * img[r-2+i][c-2*CH+j*CH];
        acc = acc >>> TB_SHIFT;
        if (acc < 0) acc = 0;
        if (acc > 255) acc = 255;
        expq.push_back('{acc, (c == rlen[r] - 1)});
      end
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_s_ready"}, s_ready, 0);
    check({pfx, "_m_valid"}, m_valid, 0);
    check({pfx, "_m_data"},  m_data,  0);
    check({pfx, "_m_eol"},   m_eol,   0);
    check({pfx, "_busy"},    busy,    0);
    check({pfx, "_err_len"}, err_len, 0);
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    cfg_we  = 1'b0;
    m_ready = 1'b1;
    reset   = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic load_kernel();
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      cfg_we   = 1'b1;
      cfg_addr = 4'(i);
      cfg_data = 8'(kern[i]);
    end
    for (int a = 9; a < 16; a++) begin
      @(negedge clock);
      cfg_addr = 4'(a);
      cfg_data = 8'($urandom_range(0, 255));
    end
    @(negedge clock);
    cfg_we = 1'b0;
  endtask

  task automatic run_frame(input int stall_at, input bit rand_bp, input int cfgwe_at,
                           input int abort_at, input bit lat_chk);
    int   ptr = 0, nout = 0, cyc = 0, stall_left = 0, acc_cyc = -1, first_v = -1, extra = 0;
    bit   stalled = 0, prev_hold = 0, done = 0, aborted = 0;
    int   prev_d = 0;
    bit   prev_e = 0;
    out_t e;
    while (!done) begin
      @(negedge clock);
      cyc++;
      cfg_we = 1'b0;
      if (stall_at >= 0 && nout == stall_at && !stalled) begin
        stall_left = 5;
        stalled    = 1;
      end
      if (stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end else begin
        m_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (ptr < stim.size()) begin
        s_valid = rand_bp ? ($urandom_range(0, 4) != 0) : 1'b1;
        s_data  = 8'(stim[ptr].data);
        s_sof   = stim[ptr].sof;
        s_eol   = stim[ptr].eol;
      end else begin
        s_valid = 1'b0;
      end
      if (cfgwe_at >= 0 && ptr == cfgwe_at) begin
        cfg_we   = 1'b1;
        cfg_addr = 4'($urandom_range(0, 8));
        cfg_data = 8'($urandom_range(0, 255));
      end
      #1;
      if (cfg_we) check("busy_at_cfg_we", busy, 1);
      if (prev_hold) begin
        check("hold_data", m_data, prev_d);
        check("hold_eol", m_eol, prev_e);
      end
      if (m_valid && !m_ready) check("s_ready_stall", s_ready, 0);
      prev_hold = m_valid && !m_ready;
      prev_d    = int'(m_data);
      prev_e    = m_eol;
      if (m_valid && first_v < 0) first_v = cyc;
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          check("extra_output", 1, 0);
        end else begin
          e = expq.pop_front();
          check("data", m_data, e.data);
          check("eol", m_eol, e.eol);
        end
        nout++;
        if (abort_at >= 0 && nout == abort_at) begin
          reset = 1'b0;
          #1;
          check_reset_values("abort");
          aborted = 1;
          done    = 1;
        end
      end
      if (!aborted && s_valid && s_ready) begin
        if (ptr == first_prod_idx) acc_cyc = cyc;
        ptr++;
      end
      if (ptr >= stim.size() && expq.size() == 0) done = 1;
      if (cyc > 3000) begin
        check("timeout", 0, 1);
        done = 1;
      end
    end
    s_valid = 1'b0;
    cfg_we  = 1'b0;
    m_ready = 1'b1;
    if (!aborted) begin
      if (lat_chk) check("latency", first_v - acc_cyc, 2);
      repeat (6) begin
        @(negedge clock);
        #1;
        if (m_valid) extra++;
      end
      check("no_extra_outputs", extra, 0);
    end
  endtask

  initial begin
    #2 reset = 1'b0;
    @(negedge clock);
    #1;
    check_reset_values("reset");
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_s_ready", s_ready, 1);

    // identity kernel on a ramp, latency measured
    kern = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    load_kernel();
    build_frame(4, 12, 1, 0, -1, 0);
    run_frame(-1, 0, -1, -1, 1);
    check("busy_in_run", busy, 1);

    do_reset();
    set_default_kernel();
    build_frame(4, 12, 2, 100, -1, 0);
    run_frame(-1, 0, -1, -1, 0);
    build_frame(5, 15, 3, 255, -1, 0);
    run_frame(-1, 1, -1, -1, 0);
    build_frame(5, 15, 3, 200, -1, 0);
    run_frame(-1, 1, -1, -1, 0);

    // five-cycle downstream stall mid-row
    build_frame(5, 18, 0, 0, -1, 0);
    run_frame(4, 0, -1, -1, 0);

    // short row sets err_len, next frame clears it
    build_frame(6, 12, 0, 0, 2, 10);
    run_frame(-1, 1, -1, -1, 0);
    check("err_len_set", err_len, 1);
    build_frame(4, 12, 0, 0, -1, 0);
    run_frame(-1, 1, -1, -1, 0);
    check("err_len_cleared", err_len, 0);

    // coefficient writes during RUN are ignored
    build_frame(5, 12, 0, 0, -1, 0);
    run_frame(-1, 1, 2 * 12 + 5, -1, 0);

    for (int f = 0; f < 6; f++) begin
      build_frame(int'($urandom_range(3, 7)), int'($urandom_range(9, 24)), 0, 0, -1, 0);
      run_frame(-1, 1, -1, -1, 0);
    end

    // reset mid-RUN, then a frame must use the default kernel again
    do_reset();
    for (int i = 0; i < 9; i++) kern[i] = int'($urandom_range(0, 255)) - 128;
    load_kernel();
    build_frame(5, 12, 0, 0, -1, 0);
    run_frame(-1, 0, -1, 3, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    set_default_kernel();
    build_frame(4, 15, 0, 0, -1, 0);
    run_frame(-1, 1, -1, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv3x3_stream.md
Name: conv3x3_stream

Overview:
- Streaming 3x3 signed-kernel convolution over interleaved multi-channel pixel rows.
- Successor to the row-buffered sharpen processor. Adds parametrised pixel/coefficient width, channel count and line depth, runtime-loadable kernel, output scaling shift, and valid/ready backpressure on both sides.
- Sits between the row receiver and the transmitter in the image path.

Parameters:
- PIX_W, 8: bits per channel sample.
- COEF_W, 8: signed coefficient width.
- CHANNELS, 3: interleaved channels per pixel. Horizontal neighbour stride is CHANNELS samples.
- MAX_LINE, 2820: maximum samples per row, i.e. line-buffer depth.
- SHIFT, 0: arithmetic right shift applied to the sum before clamping.

Ports:
- clock  in  1  single system clock.
- reset  in  1  asynchronous, active-low reset.
- cfg_line_len  in  12  samples per row. Sampled at frame start; valid range 3*CHANNELS..MAX_LINE.
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  4  coefficient index 0..8, row-major.
- cfg_data  in  COEF_W  signed coefficient.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input accepted when s_valid && s_ready.
- s_data  in  PIX_W  input sample.
- s_sof  in  1  first sample of frame, qualified by the handshake.
- s_eol  in  1  last sample of row.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accepts.
- m_data  out  PIX_W  clamped result.
- m_eol  out  1  last output sample of row.
- busy  out  1  high in any state other than IDLE.
- err_len  out  1  sticky row-length error; cleared by the next s_sof.

Behaviour:
- Reset values:
  - Outputs: s_ready=0, m_valid=0, m_data=0, m_eol=0, busy=0, err_len=0.
  - Internal: state=IDLE, all counters 0.
  - Kernel: {0,-1,0,-1,5,-1,0,-1,0}. Line buffers are not cleared.
- States:
  - IDLE: s_ready=1. An accepted s_sof latches cfg_line_len, sets row=0 and col=1, and moves to FILL.
  - FILL: rows 0 and 1 are written into the line buffers with no output. The s_eol of row 1 moves to RUN.
  - RUN: produces outputs for rows 2 onward. A new s_sof restarts at FILL with row=0. The frame ends on an s_sof or a return to IDLE.
  - Accepted samples without s_sof in IDLE are dropped.
- Window:
  - Tap (r,c), r=0 is the oldest row, reads sample col-2*CHANNELS+c*CHANNELS from row (current-2+r).
  - Output is produced only when col >= 2*CHANNELS.
  - Each row gives line_len-2*CHANNELS outputs. Each frame gives rows-2 output rows.
  - m_eol is asserted on the last output of each row.
- Arithmetic:
  - Each operand is zero-extended to PIX_W+1 signed bits.
  - Accumulator width is PIX_W+COEF_W+5, which is exact with no overflow.
  - The sum is arithmetic-shifted right by SHIFT, then clamped to [0, 2^PIX_W-1].
- Pipeline and handshake:
  - Latency: 2 cycles from input acceptance to m_valid (stage 1 multiply, stage 2 sum/shift/clamp).
  - Pipeline advances when !m_valid || m_ready. s_ready follows the same condition in FILL and RUN.
  - m_data and m_eol hold stable while m_valid && !m_ready.
- Row length:
  - If s_eol arrives with col != line_len, or col reaches line_len without s_eol, set err_len. That row is treated as ended, col resets, and the row counter still advances.
- Coefficient writes:
  - Accepted only in IDLE. cfg_we while busy is ignored.
  - cfg_addr > 8 is ignored.
- Simultaneous s_sof and s_eol on one sample: s_sof takes precedence.
- Reset mid-frame: returns to IDLE within the same edge, clears the pipeline, and restores the default kernel.

Decomposition:
- Package conv_pkg holds:
  - state encoding (IDLE/FILL/RUN);
  - default kernel constant array;
  - accumulator-width constant function;
  - clamp function.
- Sub-module conv_line_buffer: a single-clock ring of two MAX_LINE x PIX_W simple dual-port memories with a rotating write-row select. It returns taps for the two older rows at the current column.

Test Plan:
- Identity kernel (centre=1, others 0), CHANNELS=3, line_len=12, 4 rows of a ramp (sample = index).
  - Expect 6 outputs per row, 2 rows, each equal to the centre input.
  - m_eol on output 6 of each row; first m_valid 2 cycles after the enabling input.
- Default sharpen on a flat 100 field → all outputs 100.
- Default sharpen, centre 255 with neighbours 0 → 255 (clamped from 1275).
- Default sharpen, centre 0 with neighbours 200 → 0 (clamped from -800).
- m_ready held low 5 cycles mid-row.
  - s_ready drops within 1 cycle; m_data stays stable.
  - No sample is lost or duplicated; output count stays exact.
- Row with s_eol at col 10 (line_len 12) → err_len=1, next row processed normally; err_len clears on the next s_sof.
- cfg_we during RUN leaves the kernel unchanged.
- reset asserted mid-RUN → all outputs take reset values immediately, and a new frame after release uses the default kernel.
